// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths and the Sobel kernel convention
// used by the edge-detect stages.
package sobel_pkg;

   localparam int G_W   = 11;
   localparam int SQ_W  = 20;
   localparam int OUT_W = 21;

   typedef logic [7:0]            pix_t;
   typedef logic signed [G_W-1:0] grad_t;

   // Taps 1,2,1 along one window edge minus 1,2,1 along the
   // opposite edge; the middle tap is doubled.
   function automatic grad_t sobel_kernel(
      input pix_t p0, input pix_t p1, input pix_t p2,
      input pix_t n0, input pix_t n1, input pix_t n2
   );
      grad_t pos;
      grad_t neg;
      pos = $signed({3'b000, p0}) + $signed({2'b00, p1, 1'b0})
          + $signed({3'b000, p2});
      neg = $signed({3'b000, n0}) + $signed({2'b00, n1, 1'b0})
          + $signed({3'b000, n2});
      return pos - neg;
   endfunction

   // Square of a gradient; |g| <= 1020 so the square fits SQ_W.
   function automatic logic [SQ_W-1:0] grad_sq(input grad_t g);
      logic [G_W-1:0]   m;
      logic [2*G_W-1:0] p;
      m = g[G_W-1] ? $unsigned(-g) : $unsigned(g);
      p = {{G_W{1'b0}}, m} * {{G_W{1'b0}}, m};
      return SQ_W'(p);
   endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: one image line of 8-bit pixels.
// Async read returns the pre-write word in the write cycle.
import sobel_pkg::*;

module sobel_line_buf #(
   parameter int DEPTH = 640,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  pix_t          wdata,
   output pix_t          rdata
);

   pix_t mem_q [DEPTH];

   assign rdata = mem_q[addr];

   // Write port; contents are never cleared.
   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wdata;
   end

endmodule

// File: rtl/sobel_mag_sq.sv
// sobel_mag_sq: streaming 3x3 Sobel, emits Gx^2+Gy^2 per
// accepted pixel four clocks later.
import sobel_pkg::*;

module sobel_mag_sq #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int PIX_W = 8,
   parameter int OUT_W = 21
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_vaild,
   input  logic             i_sof,
   input  logic [PIX_W-1:0] data_i,
   output logic             o_vaild,
   output logic [OUT_W-1:0] data_o
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic            in_v_q, in_v_d;
   logic            in_sof_q, in_sof_d;
   pix_t            in_pix_q, in_pix_d;
   logic [CW-1:0]   col_q, col_d, cur_col;
   logic [RW-1:0]   row_q, row_d, cur_row;
   logic [2:0][2:0][7:0] win_q, win_d;
   logic            v1_q, v1_d, bord_q, bord_d;
   grad_t           gx_q, gx_d, gy_q, gy_d;
   logic            v2_q, v2_d;
   logic [SQ_W-1:0] gx2_q, gx2_d, gy2_q, gy2_d;
   logic            v3_q, v3_d;
   logic [OUT_W-1:0] sum_q, sum_d;
   logic            v4_q, v4_d;
   logic [SQ_W:0]   sum_full;
   pix_t            lb0_rd, lb1_rd;

   sobel_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
      .clk   (clk),
      .we    (in_v_q),
      .addr  (cur_col),
      .wdata (in_pix_q),
      .rdata (lb0_rd)
   );

   sobel_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
      .clk   (clk),
      .we    (in_v_q),
      .addr  (cur_col),
      .wdata (lb0_rd),
      .rdata (lb1_rd)
   );

   // Input capture, position tracking and window shift.
   always_comb begin
      in_v_d   = i_vaild;
      in_sof_d = i_vaild & i_sof;
      in_pix_d = data_i;
      cur_col  = in_sof_q ? '0 : col_q;
      cur_row  = in_sof_q ? '0 : row_q;
      col_d    = col_q;
      row_d    = row_q;
      win_d    = win_q;
      v1_d     = in_v_q;
      bord_d   = 1'b0;
      if (in_v_q) begin
         if (cur_col == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (cur_row == RW'(IMG_H - 1)) ? '0
                  : cur_row + RW'(1);
         end else begin
            col_d = cur_col + CW'(1);
            row_d = cur_row;
         end
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = lb1_rd;
         win_d[1][2] = lb0_rd;
         win_d[2][2] = in_pix_q;
         bord_d = (cur_row < RW'(2)) || (cur_col < CW'(2));
      end
   end

   // Kernel, squares and sum; invalid or border slots carry 0.
   always_comb begin
      gx_d = '0;
      gy_d = '0;
      if (v1_q && !bord_q) begin
         gx_d = sobel_kernel(win_q[0][2], win_q[1][2], win_q[2][2],
                             win_q[0][0], win_q[1][0], win_q[2][0]);
         gy_d = sobel_kernel(win_q[2][0], win_q[2][1], win_q[2][2],
                             win_q[0][0], win_q[0][1], win_q[0][2]);
      end
      v2_d     = v1_q;
      gx2_d    = grad_sq(gx_q);
      gy2_d    = grad_sq(gy_q);
      v3_d     = v2_q;
      sum_full = {1'b0, gx2_q} + {1'b0, gy2_q};
      sum_d    = v3_q ? OUT_W'(sum_full) : '0;
      v4_d     = v3_q;
   end

   // Pipeline registers; reset flushes every in-flight slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_v_q   <= 1'b0;
         in_sof_q <= 1'b0;
         in_pix_q <= '0;
         col_q    <= '0;
         row_q    <= '0;
         win_q    <= '0;
         v1_q     <= 1'b0;
         bord_q   <= 1'b0;
         gx_q     <= '0;
         gy_q     <= '0;
         v2_q     <= 1'b0;
         gx2_q    <= '0;
         gy2_q    <= '0;
         v3_q     <= 1'b0;
         sum_q    <= '0;
         v4_q     <= 1'b0;
      end else begin
         in_v_q   <= in_v_d;
         in_sof_q <= in_sof_d;
         in_pix_q <= in_pix_d;
         col_q    <= col_d;
         row_q    <= row_d;
         win_q    <= win_d;
         v1_q     <= v1_d;
         bord_q   <= bord_d;
         gx_q     <= gx_d;
         gy_q     <= gy_d;
         v2_q     <= v2_d;
         gx2_q    <= gx2_d;
         gy2_q    <= gy2_d;
         v3_q     <= v3_d;
         sum_q    <= sum_d;
         v4_q     <= v4_d;
      end
   end

   assign o_vaild = v4_q;
   assign data_o  = sum_q;

endmodule

// File: tb/tb_sobel_mag_sq.sv
// tb_sobel_mag_sq: directed frames on an 8x6 image with a
// queue scoreboard checked by an independent monitor.
module tb_sobel_mag_sq;

   localparam int W = 8;
   localparam int H = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        i_vaild = 1'b0;
   logic        i_sof = 1'b0;
   logic [7:0]  data_i = '0;
   logic        o_vaild;
   logic [20:0] data_o;

   typedef struct {
      logic [20:0] data;
      int          exp_e;
   } exp_t;

   exp_t sb [$];
   exp_t mon_e;
   int   edge_n = 0;
   int   pulses = 0;
   int   checks = 0;
   int   failures = 0;

   sobel_mag_sq #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .OUT_W(21)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_vaild (i_vaild),
      .i_sof   (i_sof),
      .data_i  (data_i),
      .o_vaild (o_vaild),
      .data_o  (data_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic void chk(string nm, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endfunction

   // pattern 0 flat, 1 vertical edge at col 4, 2 corner (col>=4 or row>=4)
   function automatic logic [7:0] pix(int pat, int c, int r);
      case (pat)
         0: return 8'd100;
         1: return (c >= 4) ? 8'd255 : 8'd0;
         default: return (c >= 4 || r >= 4) ? 8'd255 : 8'd0;
      endcase
   endfunction

   // Hand-derived results for the newest pixel at (c,r).
   function automatic logic [20:0] exp_val(int pat, int c, int r);
      if (r < 2 || c < 2 || pat == 0) return 21'd0;
      if (pat == 1) return (c == 4 || c == 5) ? 21'd1040400 : 21'd0;
      if (c == 2 || c == 3) return (r >= 4) ? 21'd1040400 : 21'd0;
      if (c == 4) begin
         if (r <= 3) return 21'd1040400;
         return (r == 4) ? 21'd1170450 : 21'd650250;
      end
      if (c == 5) begin
         if (r <= 3) return 21'd1040400;
         return (r == 4) ? 21'd650250 : 21'd130050;
      end
      return 21'd0;
   endfunction

   task automatic send(input bit sof, input logic [7:0] d,
                       input logic [20:0] e);
      @(posedge clk);
      #1;
      i_vaild = 1'b1;
      i_sof   = sof;
      data_i  = d;
      sb.push_back('{e, edge_n + 5});
   endtask

   task automatic idle(input int n, input bit sof);
      repeat (n) begin
         @(posedge clk);
         #1;
         i_vaild = 1'b0;
         i_sof   = sof;
         data_i  = 8'($urandom);
      end
   endtask

   task automatic frame(input int pat, input int gap, input bit sof0);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            send(sof0 && r == 0 && c == 0, pix(pat, c, r),
                 exp_val(pat, c, r));
            if (gap > 0) idle(gap, 1'b1);
         end
      end
   endtask

   task automatic partial(input int pat, input int n);
      for (int i = 0; i < n; i++)
         send(1'b0, pix(pat, i % W, i / W), exp_val(pat, i % W, i / W));
   endtask

   task automatic drain(input string nm);
      idle(1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
      end
      @(negedge clk);
      chk(nm, sb.size(), 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n   = 1'b0;
      i_vaild = 1'b0;
      i_sof   = 1'b0;
      while (sb.size() > 0 && sb[$].exp_e >= edge_n)
         void'(sb.pop_back());
      repeat (4) begin
         @(posedge clk);
         #1;
         i_vaild = ~i_vaild;
      end
      chk("midrst_o_vaild", o_vaild, 0);
      @(posedge clk);
      #1;
      i_vaild = 1'b0;
      rst_n   = 1'b1;
   endtask

   // Monitor: pops one expectation per output pulse.
   always @(negedge clk) begin
      if (o_vaild === 1'b1) begin
         if (sb.size() == 0) begin
            chk("spurious_valid", o_vaild, 0);
         end else begin
            mon_e = sb.pop_front();
            pulses++;
            chk("latency_edge", edge_n, mon_e.exp_e);
            chk("data_o", data_o, mon_e.data);
         end
      end else begin
         chk("idle_zero", data_o, 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int p0;
      #1;
      rst_n = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
         i_vaild = ~i_vaild;
         i_sof   = ~i_sof;
      end
      chk("rst_o_vaild", o_vaild, 0);
      chk("rst_data_o", data_o, 0);
      i_vaild = 1'b0;
      i_sof   = 1'b0;
      rst_n   = 1'b1;
      idle(8, 1'b0);

      p0 = pulses;
      frame(0, 0, 1'b0);
      drain("flat_drain");
      chk("flat_pulses", pulses - p0, W * H);

      frame(1, 0, 1'b0);
      drain("vedge_drain");

      frame(2, 0, 1'b0);
      drain("corner_drain");

      p0 = pulses;
      frame(1, 2, 1'b0);
      drain("gapped_drain");
      chk("gapped_pulses", pulses - p0, W * H);

      partial(1, 20);
      frame(1, 0, 1'b1);
      drain("sof_drain");

      partial(1, 30);
      do_reset();
      idle(10, 1'b0);
      frame(1, 0, 1'b0);
      drain("reset_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sobel_mag_sq.md
# sobel_mag_sq

Streaming 3×3 Sobel stage that turns a raster grayscale pixel stream into squared gradient magnitude Gx²+Gy². It sits directly upstream of the pipelined integer square-root stage: `data_o`/`o_vaild` connect straight to that stage's 21-bit `data_i`/`i_vaild`. It holds two line buffers and a 3×3 window, and emits one result per accepted pixel at a fixed latency, with no backpressure.

## Interface
- `IMG_W`, 640, active pixels per line (≥3)
- `IMG_H`, 480, lines per frame (≥3)
- `PIX_W`, 8, input pixel width; only 8 is supported
- `OUT_W`, 21, output width; fixed by PIX_W=8
- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous, active-low reset
- `i_vaild`  in  1  `data_i` valid this cycle; may drop for any number of cycles
- `i_sof`  in  1  qualified by `i_vaild`; marks pixel (0,0) of a frame
- `data_i`  in  8  unsigned grayscale pixel
- `o_vaild`  out  1  `data_o` valid; one pulse per accepted pixel
- `data_o`  out  21  unsigned Gx²+Gy²

## Operation
- Position counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on `i_vaild`.
  - `col` wraps to 0 and increments `row`.
  - `row` wraps to 0 after the pixel at (IMG_W-1, IMG_H-1).
- `i_vaild`&`i_sof` forces the current pixel to be (0,0), whatever the counter state. Counters continue from there.
- `i_sof` without `i_vaild` is ignored.
- Line buffers:
  - lb0 holds row-1.
  - lb1 holds row-2.
  - Each has depth IMG_W and is addressed by `col`.
  - On an accepted pixel: read the old lb0[col] and lb1[col], write lb1[col]←old lb0[col] and lb0[col]←`data_i` (read-before-write).
- Window: 3×3 shift register p[r][c]. r=0 is the oldest row, c=0 is the oldest column. On acceptance, the new column {lb1[col], lb0[col], data_i} shifts in at c=2.
- Gx = (p02+2p12+p22) − (p00+2p10+p20).
- Gy = (p20+2p21+p22) − (p00+2p01+p02).
- Gx and Gy are 11-bit signed, range ±1020.
- Gx² and Gy² are 20-bit unsigned. Their sum is 21-bit unsigned, maximum 2,080,800 < 2²¹. No saturation or truncation is needed.
- Result is for the window centred at (col-1,row-1) of the newest pixel. The output is spatially one line plus one pixel behind the input.
- Border masking: if the newest pixel has row<2 or col<2, the output is 0 but `o_vaild` still pulses.
- Line-buffer contents are never cleared. Border masking makes stale data invisible.
- Output count always equals input count.

## Timing
- Reset values: `o_vaild`=0, `data_o`=0. Counters, window and all stage valid bits are 0.
- Pipeline, counted from the edge that accepts a pixel:
  - Edge 1: window and line-buffer update, border flag registered.
  - Edge 2: Gx/Gy registered.
  - Edge 3: squares registered.
  - Edge 4: sum registered into `data_o`, `o_vaild`=1.
- Latency is exactly 4 clocks. If `i_vaild` is high on edge n, `o_vaild` is high after edge n+4.
- Downstream stages advance every clock, regardless of `i_vaild`. Each stage carries its own valid bit.
- With back-to-back input, the output is back-to-back.
- When `o_vaild`=0, `data_o` is 0.
- Reset mid-frame:
  - Flushes all in-flight results; no `o_vaild` follows release.
  - The next accepted pixel is treated as (0,0).

## Structure
- Shared package `sobel_pkg` holds:
  - G_W=11, SQ_W=20, OUT_W=21 localparams.
  - The `sobel_kernel` coefficient convention, also used by any later edge stages.
- One sub-module: `sobel_line_buf`, a depth-IMG_W, 8-bit read-before-write buffer inferable as Gowin BSRAM/SSRAM. It is instantiated twice.
- The top holds the counters, window, kernel, square, sum and valid pipeline.

## Test plan
- Reset: hold `rst_n`=0 with `i_vaild` toggling → `o_vaild`=0, `data_o`=0. After release with idle input → no `o_vaild`.
- IMG_W=8, IMG_H=6, flat frame of 100 → 48 `o_vaild` pulses, each 4 clocks after its input, all `data_o`=0.
- Same size, cols 0–3=0 and cols 4–7=255:
  - Rows ≥2, newest col 4 and 5 → `data_o`=1,040,400.
  - Every other output → 0.
- Corner: 3×3 window with right column and bottom row =255, rest 0 → Gx=Gy=765, `data_o`=1,170,450.
- Gapped input, `i_vaild` every 3rd cycle, vertical-edge frame → values identical to the contiguous run, each exactly 4 clocks after its input.
- `i_sof` asserted at pixel 20 of a frame → counters restart and the next two lines output 0. Separately, `rst_n` pulse mid-frame → in-flight outputs dropped and the next pixel is treated as (0,0).
